// File: rtl/lockin_demod.sv
// Lock-in reference generator and I/Q mixer: NCO + quarter-wave sin/cos ROM, signed ADC x reference products.
// Latency: fixed 4 clk from adc_tick to out_tick; accepts one sample every 2 clk.
// Backpressure: none; every sample yields exactly one out_tick, and the consumer must keep up.
//
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   adc_tick, adc_in    - sample strobe and signed ADC sample
//   ftw, phase_ofs      - tuning word and reference phase offset, taken on adc_tick
//   phase_clr           - accumulator re-sync (wins over the increment)
//   harm_sel            - 2nd-harmonic select; used only when LOCKIN_HARM2_EN is defined
//   out_tick, i_out, q_out - result strobe, adc*cos and adc*sin
//
// Build option: define LOCKIN_HARM2_EN to enable 2f lookup (phase = 2*acc + phase_ofs) when harm_sel=1.

module lockin_demod #(
  parameter int PHASE_W = 32,
  parameter int ADC_W   = 16,
  parameter int LUT_AW  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      adc_tick,
  input  logic signed [ADC_W-1:0]   adc_in,
  input  logic [PHASE_W-1:0]        ftw,
  input  logic [PHASE_W-1:0]        phase_ofs,
  input  logic                      phase_clr,
  input  logic                      harm_sel,
  output logic                      out_tick,
  output logic signed [2*ADC_W-1:0] i_out,
  output logic signed [2*ADC_W-1:0] q_out
);

  localparam int PW     = 2 * ADC_W;
  localparam int REF_W  = 17;
  localparam int LUT_N  = 1 << LUT_AW;
  localparam longint PI_Q30 = 64'sd3373259426;

  // Quarter-wave entry k = round(32767 * sin(pi*(2k+1)/(4*LUT_N))), evaluated at
  // elaboration in Q30 fixed point with a Taylor series.
  function automatic logic [15:0] lut_val(input int k);
    longint x, x2, term, sum;
    x    = (PI_Q30 * longint'(2 * k + 1)) / longint'(4 * LUT_N);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      sum  = sum + term;
    end
    return 16'((sum * 64'sd32767 + (64'sd1 <<< 29)) >>> 30);
  endfunction

  logic [15:0] lut_rom [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_rom
    localparam logic [15:0] ENTRY = lut_val(k);
    assign lut_rom[k] = ENTRY;
  end

  typedef struct packed {
    logic signed [ADC_W-1:0] adc;
    logic [1:0]              quad;
    logic [LUT_AW-1:0]       addr;
  } s1_t;

  typedef struct packed {
    logic signed [ADC_W-1:0] adc;
    logic signed [REF_W-1:0] sin_ref;
    logic signed [REF_W-1:0] cos_ref;
  } s2_t;

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] acc_base;
  logic [PHASE_W-1:0] samp_phase;
  logic               s1_vld, s2_vld, s3_vld;
  s1_t                s1_dat, s1_nxt;
  s2_t                s2_dat, s2_nxt;
  logic signed [PW-1:0] s3_i, s3_q;
  logic [15:0]        mag_a, mag_na;

  // A clear coincident with a tick makes this sample see acc = 0.
  assign acc_base = phase_clr ? '0 : acc;

`ifdef LOCKIN_HARM2_EN
  assign samp_phase = harm_sel ? ((acc_base << 1) + phase_ofs) : (acc_base + phase_ofs);
`else
  assign samp_phase = acc_base + phase_ofs;
  logic unused_harm;
  assign unused_harm = harm_sel;
`endif

  // Only the quadrant and ROM address bits of the phase reach the lookup.
  logic unused_phase_lsbs;
  assign unused_phase_lsbs = ^samp_phase[PHASE_W-LUT_AW-3:0];

  always_comb begin
    s1_nxt      = s1_dat;
    s1_nxt.adc  = adc_in;
    s1_nxt.quad = samp_phase[PHASE_W-1 -: 2];
    s1_nxt.addr = samp_phase[PHASE_W-3 -: LUT_AW];
  end

  // Quadrant fold: odd quadrants read the mirrored address, quadrants 2/3 negate.
  // cos is sin one quadrant ahead, so it mirrors on even quadrants and is
  // negative in quadrants 1 and 2.
  always_comb begin
    mag_a          = lut_rom[s1_dat.addr];
    mag_na         = lut_rom[~s1_dat.addr];
    s2_nxt         = '0;
    s2_nxt.adc     = s1_dat.adc;
    s2_nxt.sin_ref = s1_dat.quad[0] ? {1'b0, mag_na} : {1'b0, mag_a};
    s2_nxt.cos_ref = s1_dat.quad[0] ? {1'b0, mag_a}  : {1'b0, mag_na};
    if (s1_dat.quad[1])
      s2_nxt.sin_ref = -s2_nxt.sin_ref;
    if (s1_dat.quad[1] ^ s1_dat.quad[0])
      s2_nxt.cos_ref = -s2_nxt.cos_ref;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      s3_vld   <= 1'b0;
      out_tick <= 1'b0;
      s1_dat   <= '0;
      s2_dat   <= '0;
      s3_i     <= '0;
      s3_q     <= '0;
      i_out    <= '0;
      q_out    <= '0;
    end else begin
      if (adc_tick)
        acc <= acc_base + ftw;
      else if (phase_clr)
        acc <= '0;

      s1_vld <= adc_tick;
      if (adc_tick)
        s1_dat <= s1_nxt;

      s2_vld <= s1_vld;
      s2_dat <= s2_nxt;

      // |ref| <= 32767 so the product always fits in PW bits.
      s3_vld <= s2_vld;
      s3_i   <= PW'(s2_dat.adc) * PW'(s2_dat.cos_ref);
      s3_q   <= PW'(s2_dat.adc) * PW'(s2_dat.sin_ref);

      out_tick <= s3_vld;
      if (s3_vld) begin
        i_out <= s3_i;
        q_out <= s3_q;
      end
    end
  end

endmodule

// File: tb/tb_lockin_demod.sv
module tb_lockin_demod;

  logic               clk = 1'b0;
  logic               rst;
  logic               adc_tick;
  logic signed [15:0] adc_in;
  logic [31:0]        ftw;
  logic [31:0]        phase_ofs;
  logic               phase_clr;
  logic               harm_sel;
  logic               out_tick;
  logic signed [31:0] i_out;
  logic signed [31:0] q_out;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;
  longint cap_i[$];
  longint cap_q[$];

  lockin_demod dut (
    .clk      (clk),
    .rst      (rst),
    .adc_tick (adc_tick),
    .adc_in   (adc_in),
    .ftw      (ftw),
    .phase_ofs(phase_ofs),
    .phase_clr(phase_clr),
    .harm_sel (harm_sel),
    .out_tick (out_tick),
    .i_out    (i_out),
    .q_out    (q_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_tick) begin
      tick_cnt++;
      cap_i.push_back(longint'(i_out));
      cap_q.push_back(longint'(q_out));
    end
  end

  typedef struct {
    logic [31:0]        ofs;
    logic signed [15:0] adc;
    longint             exp_i;
    longint             exp_q;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Tick issued in cycle N; returns at the falling edge of cycle N+1.
  task automatic drive_tick(input logic signed [15:0] a, input logic clr);
    @(negedge clk);
    adc_in    = a;
    adc_tick  = 1'b1;
    phase_clr = clr;
    @(negedge clk);
    adc_tick  = 1'b0;
    phase_clr = 1'b0;
  endtask

  // Called right after drive_tick: expects out_tick exactly in cycle N+4.
  task automatic check_result(input string name, input longint ei, input longint eq);
    repeat (2) @(negedge clk);
    check({name, "_early"}, longint'(out_tick), 0);
    @(negedge clk);
    check({name, "_tick"}, longint'(out_tick), 1);
    check({name, "_i"}, longint'(i_out), ei);
    check({name, "_q"}, longint'(q_out), eq);
    @(negedge clk);
    check({name, "_pulse"}, longint'(out_tick), 0);
  endtask

  initial begin
    int snap;
    longint hold_i;

    rst = 1'b1; adc_tick = 1'b0; adc_in = '0; ftw = '0;
    phase_ofs = '0; phase_clr = 1'b0; harm_sel = 1'b0;

    // lut[0]=101, lut[255]=32767, lut[127]=23099, lut[128]=23241
    vecs[0] = '{32'h0000_0000,   16'sd1000,  64'sd32767000,   64'sd101000};
    vecs[1] = '{32'h4000_0000,   16'sd1000, -64'sd101000,     64'sd32767000};
    vecs[2] = '{32'h0000_0000, -16'sd32768, -64'sd1073709056, -64'sd3309568};
    vecs[3] = '{32'h8000_0000,   16'sd1000, -64'sd32767000,  -64'sd101000};
    vecs[4] = '{32'hC000_0000,   16'sd1000,  64'sd101000,    -64'sd32767000};
    vecs[5] = '{32'h3FC0_0000,   16'sd1000,  64'sd101000,     64'sd32767000};
    vecs[6] = '{32'h0000_0000,   16'sd32767, 64'sd1073676289, 64'sd3309467};
    vecs[7] = '{32'h2000_0000,  -16'sd1,    -64'sd23099,     -64'sd23241};
    vecs[8] = '{32'h003F_FFFF,   16'sd2,     64'sd65534,      64'sd202};

    repeat (3) @(negedge clk);
    check("rst_tick", longint'(out_tick), 0);
    check("rst_i", longint'(i_out), 0);
    check("rst_q", longint'(q_out), 0);
    rst = 1'b0;

    // Single-sample table; phase_clr with each tick pins phase to phase_ofs.
    ftw = 32'h1234_5678;
    for (int v = 0; v < 9; v++) begin
      phase_ofs = vecs[v].ofs;
      drive_tick(vecs[v].adc, 1'b1);
      check_result($sformatf("vec%0d", v), vecs[v].exp_i, vecs[v].exp_q);
    end

    // Outputs hold between strobes.
    hold_i = longint'(i_out);
    repeat (6) @(negedge clk);
    check("hold_i", longint'(i_out), hold_i);
    check("hold_q", longint'(q_out), 202);

    // Accumulator wrap over 257 ticks spaced 3 cycles.
    do_reset();
    ftw = 32'h0100_0000; phase_ofs = '0; adc_in = 16'sd1000;
    tick_cnt = 0; cap_i.delete(); cap_q.delete();
    for (int t = 0; t < 257; t++) begin
      @(negedge clk); adc_tick = 1'b1;
      @(negedge clk); adc_tick = 1'b0;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("wrap_count", longint'(tick_cnt), 257);
    if (cap_i.size() == 257) begin
      check("wrap_i_eq", cap_i[256], cap_i[0]);
      check("wrap_q_eq", cap_q[256], cap_q[0]);
      check("wrap_t1_i", cap_i[0], 64'sd32767000);
      check("wrap_t65_i", cap_i[64], -64'sd101000);
      check("wrap_t65_q", cap_q[64], 64'sd32767000);
      check("wrap_t129_i", cap_i[128], -64'sd32767000);
      check("wrap_t193_q", cap_q[192], -64'sd32767000);
    end

    // phase_clr coincident with tick 6, then alone.
    do_reset();
    ftw = 32'h4000_0000; phase_ofs = '0;
    for (int t = 0; t < 5; t++) drive_tick(16'sd1000, 1'b0);
    repeat (3) @(negedge clk);
    drive_tick(16'sd1000, 1'b1);
    check_result("clr_t6", 64'sd32767000, 64'sd101000);
    drive_tick(16'sd1000, 1'b0);
    check_result("clr_t7", -64'sd101000, 64'sd32767000);
    @(negedge clk); phase_clr = 1'b1;
    @(negedge clk); phase_clr = 1'b0;
    drive_tick(16'sd1000, 1'b0);
    check_result("clr_alone", 64'sd32767000, 64'sd101000);

    // Reset two cycles after a tick discards it.
    phase_ofs = 32'h8000_0000;
    snap = tick_cnt;
    drive_tick(16'sd1000, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rstmid_tick", longint'(out_tick), 0);
    repeat (4) @(negedge clk);
    check("rstmid_cnt", longint'(tick_cnt), longint'(snap));
    check("rstmid_i", longint'(i_out), 0);
    check("rstmid_q", longint'(q_out), 0);
    phase_ofs = '0;
    drive_tick(16'sd1000, 1'b0);
    check_result("post_rst", 64'sd32767000, 64'sd101000);

    // Second-harmonic select.
    do_reset();
    ftw = 32'h2000_0000; phase_ofs = '0; harm_sel = 1'b1;
    drive_tick(16'sd1000, 1'b0);
    check_result("harm_t1", 64'sd32767000, 64'sd101000);
    drive_tick(16'sd1000, 1'b0);
`ifdef LOCKIN_HARM2_EN
    check_result("harm_t2", -64'sd101000, 64'sd32767000);
`else
    check_result("harm_t2", 64'sd23099000, 64'sd23241000);
`endif
    harm_sel = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lockin_demod.md
Name: lockin_demod

Overview:
- Reference generator and mixer stage directly upstream of the CIC decimators in the lock-in chain.
- On each ADC sample strobe, advances an NCO phase accumulator and looks up sin/cos from a quarter-wave ROM.
- Multiplies the signed ADC sample by both references.
- Emits signed 32-bit I and Q products with a one-cycle strobe; one CIC instance consumes each product.

Parameters:
- PHASE_W, 32, NCO accumulator, tuning word and phase-offset width.
- ADC_W, 16, signed ADC sample width; product width is 2*ADC_W = 32.
- LUT_AW, 8, quarter-wave ROM address bits (256 entries, 16-bit unsigned magnitude).

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- rst, in, 1, synchronous, active-high reset.
- adc_tick, in, 1, sample strobe; each high cycle is one sample; consecutive highs are separated by at least 1 low cycle.
- adc_in, in, ADC_W, signed ADC sample, valid while adc_tick is high.
- ftw, in, PHASE_W, frequency tuning word, sampled on adc_tick.
- phase_ofs, in, PHASE_W, reference phase offset, sampled on adc_tick.
- phase_clr, in, 1, synchronous accumulator clear (reference re-sync).
- harm_sel, in, 1, 0 = fundamental, 1 = 2nd harmonic (see Optional Feature).
- out_tick, out, 1, one-cycle strobe; I_out/Q_out valid.
- i_out, out, 32, signed adc_in * cos reference.
- q_out, out, 32, signed adc_in * sin reference.

Behaviour:
- Reset: acc=0, all pipeline valids=0, out_tick=0, i_out=0, q_out=0. Reset mid-operation discards all in-flight samples; no out_tick is produced for them.
- NCO: on adc_tick the sample phase is p = acc + phase_ofs (mod 2^PHASE_W), using acc before update; then acc <= acc + ftw. Accumulator wraps modulo 2^PHASE_W.
- phase_clr has priority over the increment:
  - phase_clr alone: acc <= 0.
  - phase_clr with adc_tick: the sample uses acc = 0 (p = phase_ofs), and acc <= ftw.
- Phase fold: q = p[31:30] (quadrant), a = p[29:22]. The ROM holds lut[k] = round(32767*sin(2*pi*(k+0.5)/1024)), k = 0..255, so lut[0] = 101 and lut[255] = 32767.
- sin(q,a):
  - q=0: +lut[a]
  - q=1: +lut[~a]
  - q=2: -lut[a]
  - q=3: -lut[~a]
- cos(q,a) = sin(q+1 mod 4, a). References never reach -32768.
- Pipeline, fixed 4-cycle latency (adc_tick in cycle N gives out_tick in cycle N+4):
  - S1: capture adc_in and p; valid.
  - S2: ROM read, quadrant sign applied; 17-bit signed sin/cos.
  - S3: signed multiply.
  - S4: output registers; out_tick = 1 for exactly one cycle.
- Arithmetic: full-precision signed 16x16 product. The 17-bit reference magnitude is at most 32767, so the result always fits in 32 bits; no saturation and no rounding.
- i_out/q_out hold their value until the next out_tick.
- Throughput: one sample per 2 clk. The out_tick spacing equals the adc_tick spacing, so the downstream rising-edge tick detector sees every result.
- ftw/phase_ofs changes take effect on the next adc_tick; there is no glitch in samples already in flight.

Optional Feature:
- Macro: LOCKIN_HARM2_EN.
- Defined: when harm_sel=1, the lookup phase is p2 = 2*acc + phase_ofs (mod 2^PHASE_W) in place of p. The accumulator update is unchanged. This gives 2f demodulation with the offset in 2f-phase units. harm_sel is sampled on adc_tick with ftw.
- Undefined: harm_sel is ignored; the lookup always uses p. No doubling logic is built.

Test Plan:
1. rst, then ftw=0, phase_ofs=0, adc_in=1000, one adc_tick -> 4 cycles later out_tick=1 for 1 cycle, i_out=32767000, q_out=101000.
2. phase_ofs=0x4000_0000, adc_in=1000 -> i_out=-101000, q_out=32767000. With adc_in=-32768, phase_ofs=0 -> i_out=-1073709056, q_out=-3309568.
3. ftw=0x0100_0000, adc_in=1000, 257 ticks spaced 3 cycles -> tick 257 output equals tick 1 output (accumulator wrap); exactly 257 out_ticks.
4. After 5 ticks assert phase_clr coincident with tick 6 -> tick 6 output equals test 1 values; tick 7 uses phase = ftw.
5. Tick at cycle N, rst at N+2 -> no out_tick at N+4; i_out=q_out=0. The next tick after rst behaves as in test 1.
6. (LOCKIN_HARM2_EN) ftw=0x2000_0000, harm_sel=1, two ticks -> second sample uses quadrant 1 (i_out=-101000, q_out=32767000 for adc_in=1000). With the macro undefined, the same stimulus gives quadrant 0, a=128 values.
